// File: rtl/adc_acq_ctrl.sv
// rtl/adc_acq_ctrl.sv - ADC acquisition sequencer: trigger delay, pipeline flush, then a
// length-sample burst into the acquisition buffer write port.
module adc_acq_ctrl #(
  parameter int DATA_W   = 10,
  parameter int PIPE_LEN = 6,
  parameter int CNT_W    = 16,
  parameter int ADDR_W   = 13
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  delay_i,
  input  logic [CNT_W-1:0]  length_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DELAY   = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int              FL_W    = (PIPE_LEN > 1) ? $clog2(PIPE_LEN) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(PIPE_LEN - 1);

  logic [2:0]        state_q,     state_d;
  logic [CNT_W-1:0]  dly_cnt_q,   dly_cnt_d;
  logic [CNT_W-1:0]  len_cnt_q,   len_cnt_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0] addr_cnt_q,  addr_cnt_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;

  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    len_cnt_d   = len_cnt_q;
    flush_cnt_d = flush_cnt_q;
    addr_cnt_d  = addr_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          dly_cnt_d  = delay_i;
          len_cnt_d  = length_i;
          addr_cnt_d = '0;
          wr_addr_d  = '0;
          state_d    = (length_i == '0) ? S_DONE : S_DELAY;
        end
      end
      S_DELAY: begin
        // delay of 0 or 1 both give a single DELAY cycle
        if (dly_cnt_q <= CNT_W'(1)) begin
          dly_cnt_d   = '0;
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end else begin
          dly_cnt_d = dly_cnt_q - CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FL_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      S_CAPTURE: begin
        // write strobe, address and data all land on the same edge
        wr_en_d    = 1'b1;
        wr_addr_d  = addr_cnt_q;
        wr_data_d  = adc_data_i;
        addr_cnt_d = addr_cnt_q + ADDR_W'(1);
        len_cnt_d  = len_cnt_q - CNT_W'(1);
        if (len_cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // DONE keeps busy up through the done pulse so busy falls one edge later
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);

    if (abort_i && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      wr_en_d   = 1'b0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      dly_cnt_q   <= '0;
      len_cnt_q   <= '0;
      flush_cnt_q <= '0;
      addr_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      len_cnt_q   <= len_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      addr_cnt_q  <= addr_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule
